// File: rtl/gray_seq_pkg.sv
// Shared definitions for the Gray-code sequencer: state encoding, default
// width and the prescaler sizing helper.
package gray_seq_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Prescaler counter width; never zero so the register always exists.
  function automatic int presc_width(input int div);
    return (clog2(div) < 1) ? 1 : clog2(div);
  endfunction

endpackage

// File: rtl/bin2gray_n.sv
// Gate-level combinational binary-to-Gray converter of arbitrary width.
module bin2gray_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o[WIDTH-1] = bin_i[WIDTH-1];

  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_xor
      assign gray_o[gi] = bin_i[gi+1] ^ bin_i[gi];
    end
  endgenerate

endmodule

// File: rtl/gray_seq_ctrl.sv
// Steps a binary index from first to last (up or down, optional wrap) and
// streams the registered Gray words on a valid/ready interface.
module gray_seq_ctrl
  import gray_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             wrap_en,
  input  logic [WIDTH-1:0] first,
  input  logic [WIDTH-1:0] last,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_gray,
  output logic [WIDTH-1:0] out_bin,
  output logic             busy,
  output logic             done
);

  localparam int              PW       = presc_width(DIV);
  localparam logic [PW-1:0]   GAP_LOAD = PW'((DIV > 1) ? DIV - 2 : 0);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] first_q, last_q;
  logic             dir_q, wrap_q;
  logic             out_valid_q, busy_q, done_q;
  logic [WIDTH-1:0] out_gray_q, gray_d;

  logic             handshake;
  logic             at_last;
  logic             start_ok;
  logic [WIDTH-1:0] step_val;

  assign handshake = out_valid_q && out_ready;
  assign at_last   = (bin_q == last_q);
  assign start_ok  = start && !stop;
  // Natural modulo-2^WIDTH arithmetic gives the wrap past 0 / all-ones.
  assign step_val  = dir_q ? (bin_q - ONE) : (bin_q + ONE);

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    presc_d = presc_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = EMIT;
          bin_d   = first;
        end
      end
      EMIT: begin
        if (stop) begin
          state_d = IDLE;
        end else if (handshake) begin
          if (at_last && !wrap_q) begin
            state_d = DONE;
          end else begin
            bin_d = at_last ? first_q : step_val;
            if (DIV > 1) begin
              state_d = GAP;
              presc_d = GAP_LOAD;
            end
          end
        end
      end
      GAP: begin
        if (stop) begin
          state_d = IDLE;
        end else if (presc_q == '0) begin
          state_d = EMIT;
        end else begin
          presc_d = presc_q - PW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  bin2gray_n #(
    .WIDTH(WIDTH)
  ) u_conv (
    .bin_i (bin_d),
    .gray_o(gray_d)
  );

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      presc_q     <= '0;
      first_q     <= '0;
      last_q      <= '0;
      dir_q       <= 1'b0;
      wrap_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_gray_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      presc_q <= presc_d;
      if (state_q == IDLE && start_ok) begin
        first_q <= first;
        last_q  <= last;
        dir_q   <= dir;
        wrap_q  <= wrap_en;
      end
      out_valid_q <= (state_d == EMIT);
      out_gray_q  <= gray_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
    end
  end

  assign out_valid = out_valid_q;
  assign out_gray  = out_gray_q;
  assign out_bin   = bin_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
